alu_gcd_ctrl: RTL and testbench

Sequencer that drives the shared ALU (max/min/modulo modes plus its multi-cycle modulo unit) to compute the greatest common divisor of two unsigned operands by Euclid's algorithm. It sits beside the ALU: it owns the ALU mode, operand and modulo-start lines, and consumes the ALU result and modulo-ready status. It returns the GCD, an iteration count and a timeout error flag through a start/valid handshake.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_gcd_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_gcd_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Constants shared between the ALU and its controllers: mode encoding, GCD sequencer states,
// default datapath width.
package alu_pkg;

    localparam int GCD_WIDTH = 16;

    localparam logic [2:0] BIGGER  = 3'd0;
    localparam logic [2:0] SMALLER = 3'd1;
    localparam logic [2:0] MODULO  = 3'd2;
    localparam logic [2:0] IDLE    = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SORT_BIG   = 3'd1,
        S_SORT_SMALL = 3'd2,
        S_CHECK      = 3'd3,
        S_MOD_START  = 3'd4,
        S_MOD_WAIT   = 3'd5,
        S_DONE       = 3'd6
    } gcd_state_e;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/alu_gcd_ctrl.sv
// Euclid GCD sequencer driving the shared ALU; all ALU-facing outputs are registered.
// state        | meaning
// S_IDLE       | waiting for start_i
// S_SORT_BIG   | ALU computes max(A,B), captured into BIG
// S_SORT_SMALL | ALU computes min(A,B), captured into SMALL
// S_CHECK      | SMALL==0 ends the loop, else launch a modulo
// S_MOD_START  | one-cycle modulo start pulse
// S_MOD_WAIT   | wait for ready rising edge or timeout
// S_DONE       | result held, valid pulsed on entry, new start accepted
module alu_gcd_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             error_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       iter_o,
    output logic [2:0]       alu_mode_o,
    output logic [WIDTH-1:0] alu_op_a_o,
    output logic [WIDTH-1:0] alu_op_b_o,
    output logic             alu_mod_start_o,
    input  logic [WIDTH-1:0] alu_res_i,
    input  logic             alu_mod_ready_i
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0] big_q, big_d, small_q, small_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       mode_q, mode_d;
    logic [4:0]       iter_q, iter_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             mod_start_q, mod_start_d;
    logic             busy_q, busy_d, valid_q, valid_d, err_q, err_d;
    logic             rdy_prev_q, rdy_prev_d;
    logic             mod_done;

    // Only a fresh rising edge of ready counts, so a level left high by the ALU cannot retrigger.
    assign mod_done = alu_mod_ready_i & ~rdy_prev_q;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        big_d       = big_q;
        small_d     = small_q;
        res_d       = res_q;
        mode_d      = mode_q;
        iter_d      = iter_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        mod_start_d = 1'b0;
        rdy_prev_d  = alu_mod_ready_i;

        case (state_q)
            S_IDLE, S_DONE: begin
                mode_d = IDLE;
                if (start_i) begin
                    op_a_d  = a_i;
                    op_b_d  = b_i;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    mode_d  = BIGGER;
                    state_d = S_SORT_BIG;
                end
            end
            S_SORT_BIG: begin
                big_d   = alu_res_i;
                mode_d  = SMALLER;
                state_d = S_SORT_SMALL;
            end
            S_SORT_SMALL: begin
                small_d = alu_res_i;
                mode_d  = IDLE;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (small_q == '0) begin
                    res_d   = big_q;
                    state_d = S_DONE;
                end else begin
                    op_a_d      = big_q;
                    op_b_d      = small_q;
                    mode_d      = MODULO;
                    mod_start_d = 1'b1;
                    state_d     = S_MOD_START;
                end
            end
            S_MOD_START: begin
                state_d = S_MOD_WAIT;
            end
            S_MOD_WAIT: begin
                if (mod_done) begin
                    big_d   = small_q;
                    small_d = alu_res_i;
                    iter_d  = sat_inc5(iter_q);
                    mode_d  = IDLE;
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    mode_d  = IDLE;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                mode_d  = IDLE;
                state_d = S_IDLE;
            end
        endcase

        busy_d  = !(state_d inside {S_IDLE, S_DONE});
        valid_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            big_q       <= '0;
            small_q     <= '0;
            res_q       <= '0;
            mode_q      <= IDLE;
            iter_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            mod_start_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            rdy_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            big_q       <= big_d;
            small_q     <= small_d;
            res_q       <= res_d;
            mode_q      <= mode_d;
            iter_q      <= iter_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            mod_start_q <= mod_start_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            rdy_prev_q  <= rdy_prev_d;
        end
    end

    assign busy_o          = busy_q;
    assign valid_o         = valid_q;
    assign error_o         = err_q;
    assign result_o        = res_q;
    assign iter_o          = iter_q;
    assign alu_mode_o      = mode_q;
    assign alu_op_a_o      = op_a_q;
    assign alu_op_b_o      = op_b_q;
    assign alu_mod_start_o = mod_start_q;

endmodule

// File: tb/tb_alu_gcd_ctrl.sv
// Randomized bench for alu_gcd_ctrl: behavioural ALU stub plus a plain-arithmetic Euclid reference.
module tb_alu_gcd_ctrl;
    import alu_pkg::*;

    localparam int W   = 16;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         busy_o, valid_o, error_o, alu_mod_start_o;
    logic [W-1:0] result_o, alu_op_a_o, alu_op_b_o;
    logic [4:0]   iter_o;
    logic [2:0]   alu_mode_o;
    logic [W-1:0] alu_res_i;
    logic         alu_mod_ready_i;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu_gcd_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .busy_o          (busy_o),
        .valid_o         (valid_o),
        .error_o         (error_o),
        .result_o        (result_o),
        .iter_o          (iter_o),
        .alu_mode_o      (alu_mode_o),
        .alu_op_a_o      (alu_op_a_o),
        .alu_op_b_o      (alu_op_b_o),
        .alu_mod_start_o (alu_mod_start_o),
        .alu_res_i       (alu_res_i),
        .alu_mod_ready_i (alu_mod_ready_i)
    );

    // ALU stub: combinational max/min, modulo unit pulses ready after 1..k_max cycles.
    bit           stub_dead = 1'b0;
    int           k_max = 2;
    int           cyc = 0;
    int           n_starts = 0;
    int           wait_tot = 0;
    int           mod_cnt = 0;
    logic         mod_rdy = 1'b0;
    logic [W-1:0] mod_res = '0, mod_pend = '0;

    always @(posedge clk) begin : stub
        int k;
        logic [W-1:0] r;
        cyc     <= cyc + 1;
        mod_rdy <= 1'b0;
        if (alu_mod_start_o) begin
            k = $urandom_range(k_max, 1);
            r = (alu_op_b_o == '0) ? '0 : alu_op_a_o % alu_op_b_o;
            n_starts <= n_starts + 1;
            mod_pend <= r;
            if (stub_dead) begin
                mod_cnt <= 0;
            end else if (k == 1) begin
                mod_rdy  <= 1'b1;
                mod_res  <= r;
                wait_tot <= wait_tot + 1;
            end else begin
                mod_cnt  <= k - 1;
                wait_tot <= wait_tot + k;
            end
        end else if (mod_cnt != 0) begin
            mod_cnt <= mod_cnt - 1;
            if (mod_cnt == 1) begin
                mod_rdy <= 1'b1;
                mod_res <= mod_pend;
            end
        end
    end

    assign alu_mod_ready_i = mod_rdy;

    always_comb begin
        alu_res_i = '0;
        case (alu_mode_o)
            BIGGER:  alu_res_i = (alu_op_a_o > alu_op_b_o) ? alu_op_a_o : alu_op_b_o;
            SMALLER: alu_res_i = (alu_op_a_o < alu_op_b_o) ? alu_op_a_o : alu_op_b_o;
            MODULO:  alu_res_i = mod_res;
            default: alu_res_i = '0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void gcd_ref(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned n);
        int unsigned x, y, t;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        n = 0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
            n++;
        end
        g = x;
        if (n > 31) n = 31;
    endfunction

    task automatic wait_valid(input bit poke, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (valid_o) begin
                start_i = 1'b0;
                seen = 1'b1;
                break;
            end
            start_i = poke && (i % 2 == 0);
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic run_gcd(input logic [W-1:0] a, input logic [W-1:0] b, input bit dead,
                           input bit poke, input string tag);
        int unsigned eg, en;
        int ws0, ns0, c0, lat, extra;
        bit seen;
        gcd_ref(a, b, eg, en);
        @(negedge clk);
        stub_dead = dead;
        a_i = a; b_i = b; start_i = 1'b1;
        ws0 = wait_tot; ns0 = n_starts; c0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom);
        check_eq({tag, "_busy_acc"}, busy_o, 1);
        check_eq({tag, "_err_acc"}, error_o, 0);
        wait_valid(poke, seen);
        check_eq({tag, "_valid_seen"}, seen, 1);
        if (seen) begin
            lat = cyc - c0;
            if (dead && en != 0) begin
                check_eq({tag, "_result"}, result_o, 0);
                check_eq({tag, "_error"}, error_o, 1);
                check_eq({tag, "_iter"}, iter_o, 0);
                check_eq({tag, "_latency"}, lat, 5 + TMO);
                check_eq({tag, "_mod_starts"}, n_starts - ns0, 1);
            end else begin
                check_eq({tag, "_result"}, result_o, eg);
                check_eq({tag, "_error"}, error_o, 0);
                check_eq({tag, "_iter"}, iter_o, en);
                check_eq({tag, "_latency"}, lat, 4 + 2 * en + (wait_tot - ws0));
                check_eq({tag, "_mod_starts"}, n_starts - ns0, en);
            end
            check_eq({tag, "_busy_done"}, busy_o, 0);
            @(negedge clk);
            check_eq({tag, "_valid_width"}, valid_o, 0);
            check_eq({tag, "_result_held"}, result_o, (dead && en != 0) ? 0 : eg);
            if (poke) begin
                extra = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (valid_o) extra++;
                end
                check_eq({tag, "_single_valid"}, extra, 0);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_valid"}, valid_o, 0);
        check_eq({tag, "_error"}, error_o, 0);
        check_eq({tag, "_result"}, result_o, 0);
        check_eq({tag, "_iter"}, iter_o, 0);
        check_eq({tag, "_mode"}, alu_mode_o, 3);
        check_eq({tag, "_op_a"}, alu_op_a_o, 0);
        check_eq({tag, "_op_b"}, alu_op_b_o, 0);
        check_eq({tag, "_mod_start"}, alu_mod_start_o, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit seen;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_gcd(16'd48, 16'd18, 1'b0, 1'b0, "g48_18");
        run_gcd(16'd0, 16'd35, 1'b0, 1'b0, "g0_35");
        run_gcd(16'd0, 16'd0, 1'b0, 1'b0, "g0_0");
        run_gcd(16'd35, 16'd0, 1'b0, 1'b0, "g35_0");
        run_gcd(16'd65535, 16'd65534, 1'b0, 1'b1, "gmax_busy");

        run_gcd(16'd48, 16'd18, 1'b1, 1'b0, "tmo");
        run_gcd(16'd100, 16'd75, 1'b0, 1'b0, "after_tmo");

        // Reset asserted while the modulo unit is in flight.
        @(negedge clk);
        stub_dead = 1'b0;
        a_i = 16'd46368; b_i = 16'd28657; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (alu_mod_start_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rstmid_mod_start_seen", seen, 1);
        @(negedge clk);
        check_eq("rstmid_in_wait_mode", alu_mode_o, 2);
        #2 rst = 1'b0;
        #1 check_reset_vals("rstmid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("rstmid_idle");
        run_gcd(16'd46368, 16'd28657, 1'b0, 1'b0, "fib");

        // Back-to-back: start_i held through DONE, second operands taken in the DONE entry cycle.
        @(negedge clk);
        a_i = 16'd48; b_i = 16'd18; start_i = 1'b1;
        @(negedge clk);
        a_i = 16'd65535; b_i = 16'd65534;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("b2b_first_valid", seen, 1);
        check_eq("b2b_first_result", result_o, 6);
        check_eq("b2b_first_iter", iter_o, 3);
        @(negedge clk);
        start_i = 1'b0;
        check_eq("b2b_reaccepted_busy", busy_o, 1);
        check_eq("b2b_valid_drop", valid_o, 0);
        wait_valid(1'b0, seen);
        check_eq("b2b_second_valid", seen, 1);
        check_eq("b2b_second_result", result_o, 1);
        check_eq("b2b_second_iter", iter_o, 2);

        for (int n = 0; n < 30; n++) begin
            ra = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom);
            run_gcd(ra, rb, 1'b0, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
